simplebus_target: RTL and testbench

- Parametrised, synthesizable external-bus target endpoint. It is the next generation of the behavioural simplebus responder model.
- Deframes byte-serial, parity-protected READ/WRITE commands arriving on the simplebus pins. Each command is issued as one transaction on a local valid/ready request port.
- Read/write acks are serialised back out, with read data.
- Adds over the responder model: configurable address/data size, a real backpressured local port, variable read latency, parity/command error detection and recovery, and busy-abort.
- Sits on the FPGA/companion side of the Microwatt external bus; also used as a bench target.

---
 rtl/simplebus_pkg.sv | 18 +
 rtl/simplebus_tx_shifter.sv | 30 +++
 rtl/simplebus_target.sv | 123 ++++++++++++
 tb/tb_simplebus_target.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simplebus_pkg.sv
// simplebus_pkg: command codes, RX state encoding and parity helper shared by the simplebus target.
package simplebus_pkg;
  localparam logic [7:0] CMD_READ      = 8'h02;
  localparam logic [7:0] CMD_WRITE     = 8'h03;
  localparam logic [7:0] CMD_READ_ACK  = 8'h82;
  localparam logic [7:0] CMD_WRITE_ACK = 8'h83;
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t ST_IDLE  = 3'd0;
  localparam rx_state_t ST_WADDR = 3'd1;
  localparam rx_state_t ST_RADDR = 3'd2;
  localparam rx_state_t ST_WSEL  = 3'd3;
  localparam rx_state_t ST_WDATA = 3'd4;
  localparam rx_state_t ST_ISSUE = 3'd5;
  localparam rx_state_t ST_RWAIT = 3'd6;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/simplebus_tx_shifter.sv
// simplebus_tx_shifter: shifts a loaded byte vector onto the bus LSB first; zero fill means idle once drained.
module simplebus_tx_shifter
  import simplebus_pkg::*;
#(
  parameter int NBYTES = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [8*NBYTES-1:0] load_vec,
  output logic [7:0]          bus_out,
  output logic                bus_pty_out,
  output logic                busy
);
  logic [8*NBYTES-1:0] sr;
  logic [7:0] nxt;
  assign nxt  = load ? load_vec[7:0] : sr[7:0];
  assign busy = |sr;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr          <= '0;
      bus_out     <= '0;
      bus_pty_out <= 1'b1;
    end else begin
      sr          <= (load ? load_vec : sr) >> 8;
      bus_out     <= nxt;
      bus_pty_out <= odd_parity(nxt);
    end
  end
endmodule

// File: rtl/simplebus_target.sv
// simplebus_target: deframes parity-protected simplebus READ/WRITE frames into local valid/ready requests
// and serialises the acks (with read data) back onto the bus.
module simplebus_target
  import simplebus_pkg::*;
#(
  parameter int ADDR_BYTES  = 4,
  parameter int DATA_BYTES  = 8,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              bus_in,
  input  logic                    bus_pty_in,
  output logic [7:0]              bus_out,
  output logic                    bus_pty_out,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_we,
  output logic [8*ADDR_BYTES-1:0] req_addr,
  output logic [DATA_BYTES-1:0]   req_sel,
  output logic [8*DATA_BYTES-1:0] req_wdata,
  input  logic                    rsp_valid,
  input  logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    err_parity,
  output logic                    err_cmd,
  output logic                    err_timeout
);
  localparam int TW = 8*(DATA_BYTES+1);
  rx_state_t state;
  logic [2:0] idx;
  logic [15:0] timer;
  logic suppress, bad, hs, wr_ack, rd_ack, tx_load, tx_busy, expired;
  logic [TW-1:0] tx_vec;
  assign bad     = bus_pty_in != odd_parity(bus_in);
  assign hs      = req_valid && req_ready;
  assign expired = timer == 16'(RSP_TIMEOUT-1);
  assign wr_ack  = state == ST_ISSUE && hs && req_we && !suppress && !bad;
  assign rd_ack  = state == ST_RWAIT && rsp_valid && !bad;
  assign tx_load = wr_ack || rd_ack;
  assign tx_vec  = rd_ack ? {rsp_rdata, CMD_READ_ACK} : TW'(CMD_WRITE_ACK);
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      timer       <= '0;
      suppress    <= 1'b0;
      req_valid   <= 1'b0;
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_sel     <= '0;
      req_wdata   <= '0;
      err_parity  <= 1'b0;
      err_cmd     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (bad) err_parity <= 1'b1;
      case (state)
        ST_IDLE: if (!bad) begin
          idx <= '0;
          if (bus_in == CMD_WRITE) state <= ST_WADDR;
          else if (bus_in == CMD_READ) state <= ST_RADDR;
          else if (bus_in != 8'h00) err_cmd <= 1'b1;
        end
        ST_WADDR, ST_RADDR: if (bad) state <= ST_IDLE; else begin
          req_addr[8*idx +: 8] <= bus_in;
          idx <= idx + 3'd1;
          if (idx == 3'(ADDR_BYTES-1)) begin
            idx   <= '0;
            state <= state == ST_WADDR ? ST_WSEL : ST_ISSUE;
            if (state == ST_RADDR) begin
              req_we    <= 1'b0;
              req_sel   <= '1;
              req_valid <= 1'b1;
            end
          end
        end
        ST_WSEL: if (bad) state <= ST_IDLE; else begin
          req_sel <= bus_in[DATA_BYTES-1:0];
          state   <= ST_WDATA;
        end
        ST_WDATA: if (bad) state <= ST_IDLE; else begin
          req_wdata[8*idx +: 8] <= bus_in;
          idx <= idx + 3'd1;
          if (idx == 3'(DATA_BYTES-1)) begin
            idx       <= '0;
            req_we    <= 1'b1;
            req_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // a corrupted byte here cannot cancel the local handshake, only its ack
          if (bad) suppress <= 1'b1;
          else if (bus_in != 8'h00) err_cmd <= 1'b1;
          if (hs) begin
            req_valid <= 1'b0;
            suppress  <= 1'b0;
            timer     <= '0;
            state     <= req_we || suppress || bad ? ST_IDLE : ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          timer <= timer + 16'd1;
          if (bad || rsp_valid || expired) state <= ST_IDLE;
          if (!bad && bus_in != 8'h00) err_cmd <= 1'b1;
          if (!bad && !rsp_valid && expired) err_timeout <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  // the host protocol guarantees the previous ack has drained before a new one is queued
  always_ff @(posedge clk) assert (rst || !tx_load || !tx_busy);
  simplebus_tx_shifter #(.NBYTES(DATA_BYTES+1)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .load       (tx_load),
    .load_vec   (tx_vec),
    .bus_out    (bus_out),
    .bus_pty_out(bus_pty_out),
    .busy       (tx_busy)
  );
endmodule

// File: tb/tb_simplebus_target.sv
// tb_simplebus_target: randomized frames against a queue-based host/endpoint model with a decoupled monitor.
module tb_simplebus_target;
  localparam int AB = 4, DB = 8, TO = 16;
  typedef struct {
    logic            we;
    logic [8*AB-1:0] addr;
    logic [DB-1:0]   sel;
    logic [8*DB-1:0] wdata;
  } req_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] bus_in = 8'h00;
  logic bus_pty_in = 1'b1, req_ready = 1'b0, rsp_valid = 1'b0;
  logic [8*DB-1:0] rsp_rdata = '0;
  logic [7:0] bus_out;
  logic bus_pty_out, req_valid, req_we, err_parity, err_cmd, err_timeout;
  logic [8*AB-1:0] req_addr;
  logic [DB-1:0] req_sel;
  logic [8*DB-1:0] req_wdata;
  int n_chk = 0, n_fail = 0;
  req_t exp_req[$];
  logic [7:0] exp_bus[$];
  logic [7:0] mon_e;
  bit pend = 0, exp_et = 0, exp_ep = 0, exp_ec = 0, fixed_rd = 0;
  int rdc = 0, rsp_lat = 1, ready_wait = 0, cd = 0, vcnt = 0;
  logic [8*DB-1:0] fixed_val = '0;

  simplebus_target #(.ADDR_BYTES(AB), .DATA_BYTES(DB), .RSP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .bus_pty_in(bus_pty_in),
    .bus_out(bus_out), .bus_pty_out(bus_pty_out),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_sel(req_sel), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err_parity(err_parity), .err_cmd(err_cmd), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // monitor: bus timeline, read-response window and request scoreboard
  initial forever begin
    @(negedge clk);
    mon_e = exp_bus.size() != 0 ? exp_bus.pop_front() : 8'h00;
    chk("bus_out", bus_out, mon_e);
    chk("bus_pty_out", bus_pty_out, ~^mon_e);
    chk("err_timeout", err_timeout, exp_et);
    if (pend) begin
      rdc++;
      if (rsp_valid) begin
        pend = 0;
        exp_bus.push_back(8'h82);
        for (int i = 0; i < DB; i++) exp_bus.push_back(rsp_rdata[8*i +: 8]);
      end else if (rdc >= TO) begin
        pend = 0;
        exp_et = 1;
      end
    end
    chk("req_valid", req_valid, exp_req.size() != 0);
    if (req_valid && exp_req.size() != 0) begin
      chk("req_we", req_we, exp_req[0].we);
      chk("req_addr", req_addr, exp_req[0].addr);
      chk("req_sel", req_sel, exp_req[0].sel);
      if (exp_req[0].we) chk("req_wdata", req_wdata, exp_req[0].wdata);
      if (req_ready) begin
        if (exp_req[0].we) exp_bus.push_back(8'h83);
        else begin
          pend = 1;
          rdc = 0;
        end
        void'(exp_req.pop_front());
      end
    end
    if (rst) begin
      exp_bus.delete();
      exp_req.delete();
      pend = 0;
      exp_et = 0;
    end
  end

  // local endpoint: ready after ready_wait valid cycles, response rsp_lat cycles after a read accept
  initial forever begin
    @(negedge clk);
    vcnt = req_valid ? vcnt + 1 : 0;
    if (req_valid && req_ready && !req_we) cd = rsp_lat;
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        rsp_valid = 1'b1;
        rsp_rdata = fixed_rd ? fixed_val : (8*DB)'({$urandom, $urandom});
      end
    end
    req_ready = vcnt >= ready_wait;
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_p);
    bus_in = b;
    bus_pty_in = (~^b) ^ bad_p;
    @(posedge clk);
    #1;
    bus_in = 8'h00;
    bus_pty_in = 1'b1;
  endtask

  task automatic send_frame(input bit we, input logic [8*AB-1:0] addr, input logic [7:0] sel_b,
                            input logic [8*DB-1:0] data, input int bad_at);
    logic [7:0] q[$];
    req_t r;
    q.push_back(we ? 8'h03 : 8'h02);
    for (int i = 0; i < AB; i++) q.push_back(addr[8*i +: 8]);
    if (we) begin
      q.push_back(sel_b);
      for (int i = 0; i < DB; i++) q.push_back(data[8*i +: 8]);
    end
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i], i == bad_at);
      if (i == bad_at) break;
    end
    if (bad_at >= 0 && bad_at < q.size()) exp_ep = 1;
    else begin
      r.we = we;
      r.addr = addr;
      r.sel = we ? sel_b[DB-1:0] : '1;
      r.wdata = data;
      exp_req.push_back(r);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_req.size() != 0 || pend || exp_bus.size() != 0 || cd != 0) && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_in_time", n < 300, 1'b1);
    @(posedge clk);
    #1;
    chk("err_parity", err_parity, exp_ep);
    chk("err_cmd", err_cmd, exp_ec);
  endtask

  initial begin
    int kind, bad_at, len, n;
    logic [7:0] b;
    bit we;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_out", bus_out, 8'h00);
    chk("rst_bus_pty_out", bus_pty_out, 1'b1);
    chk("rst_req", {req_valid, req_we, req_addr, req_sel}, '0);
    chk("rst_wdata", req_wdata, '0);
    chk("rst_errs", {err_parity, err_cmd, err_timeout}, 3'b000);
    rst = 1'b0;
    ready_wait = 0;
    send_frame(1, 32'h0000_1000, 8'hFF, 64'h1122334455667788, -1);
    wait_done();
    ready_wait = 5;
    rsp_lat = 3;
    fixed_rd = 1;
    fixed_val = 64'h0102030405060708;
    send_frame(0, 32'h0000_2000, 8'h00, '0, -1);
    wait_done();
    fixed_rd = 0;
    ready_wait = 0;
    rsp_lat = 1;
    send_frame(1, 32'hCAFE_0010, 8'h0F, 64'hDEAD_BEEF_0000_1111, 2);
    wait_done();
    send_frame(0, 32'h0000_3000, 8'h00, '0, -1);
    wait_done();
    send_byte(8'h55, 0);
    exp_ec = 1;
    wait_done();
    send_frame(1, 32'h0000_4004, 8'hA5, 64'h0F0E0D0C0B0A0908, -1);
    wait_done();
    rsp_lat = TO + 4;
    send_frame(0, 32'h0000_5000, 8'h00, '0, -1);
    wait_done();
    chk("err_timeout_set", err_timeout, 1'b1);
    rsp_lat = 2;
    send_frame(0, 32'h0000_6000, 8'h00, '0, -1);
    n = 0;
    while (!(exp_bus.size() inside {[1:5]}) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ack_started", n < 100, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_bus_out", bus_out, 8'h00);
    chk("midrst_bus_pty_out", bus_pty_out, 1'b1);
    chk("midrst_errs", {err_parity, err_cmd, err_timeout}, 3'b000);
    rst = 1'b0;
    exp_ep = 0;
    exp_ec = 0;
    send_frame(1, 32'h0000_7000, 8'h3C, 64'h8877665544332211, -1);
    wait_done();
    send_frame(0, 32'h0000_7000, 8'h00, '0, -1);
    wait_done();
    repeat (60) begin
      kind = $urandom_range(0, 9);
      ready_wait = $urandom_range(0, 3);
      rsp_lat = $urandom_range(1, TO + 3);
      if (kind == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          send_byte(8'h00, 1);
          exp_ep = 1;
        end else begin
          do b = 8'($urandom); while (b == 8'h00 || b == 8'h02 || b == 8'h03);
          send_byte(b, 0);
          exp_ec = 1;
        end
      end else begin
        we = kind >= 5;
        len = 1 + AB + (we ? 1 + DB : 0);
        bad_at = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, len - 1)) : -1;
        send_frame(we, (8*AB)'($urandom), 8'($urandom), (8*DB)'({$urandom, $urandom}), bad_at);
      end
      wait_done();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
